axi_stream_pkt_fifo: RTL and testbench

Parametrised AXI4-Stream FIFO. It carries the full sideband (tdata, tstrb, tkeep, tlast, tid, tdest, tuser) between a slave port and a master port on one clock. It offers cut-through or store-and-forward (packet) mode. It is the buffering stage between TSN frame producers and egress consumers, and it reports word and packet occupancy.

---
 rtl/axi_stream_pkt_fifo.sv | 140 ++++++++++++++
 tb/tb_axi_stream_pkt_fifo.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_pkt_fifo.sv
// AXI4-Stream FIFO carrying the full sideband, first-word-fall-through with a registered head,
// and an optional store-and-forward mode with an oversize-packet fallback to cut-through.
module axi_stream_pkt_fifo #(
    parameter int TDATA_WIDTH = 64,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 0
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         s_tvalid,
    output logic                         s_tready,
    input  logic [TDATA_WIDTH-1:0]       s_tdata,
    input  logic [TDATA_WIDTH/8-1:0]     s_tstrb,
    input  logic [TDATA_WIDTH/8-1:0]     s_tkeep,
    input  logic                         s_tlast,
    input  logic [TID_WIDTH-1:0]         s_tid,
    input  logic [TDEST_WIDTH-1:0]       s_tdest,
    input  logic [TUSER_WIDTH-1:0]       s_tuser,

    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [TDATA_WIDTH-1:0]       m_tdata,
    output logic [TDATA_WIDTH/8-1:0]     m_tstrb,
    output logic [TDATA_WIDTH/8-1:0]     m_tkeep,
    output logic                         m_tlast,
    output logic [TID_WIDTH-1:0]         m_tid,
    output logic [TDEST_WIDTH-1:0]       m_tdest,
    output logic [TUSER_WIDTH-1:0]       m_tuser,

    output logic [$clog2(DEPTH+1)-1:0]   word_count,
    output logic [$clog2(DEPTH+1)-1:0]   pkt_count,
    output logic                         overflow_err
);

    localparam int KW = TDATA_WIDTH / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = TDATA_WIDTH + 2 * KW + 1 + TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH;

    logic [WW-1:0] mem_q [DEPTH];
    logic [WW-1:0] head_q;
    logic [WW-1:0] s_word;

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] pkt_count_q, pkt_count_d;
    logic [CW-1:0] pkt_after_pop;
    logic          m_tvalid_q, m_tvalid_d;
    logic          s_tready_q, s_tready_d;
    logic          full_release_q, full_release_d;
    logic          overflow_err_q, overflow_err_d;
    logic          full_q, full_d, pkt_ready;
    logic          push, pop, push_last, pop_last;

    assign s_word = {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};
    assign {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser} = head_q;

    assign push      = s_tvalid && s_tready_q;
    assign pop       = m_tvalid_q && m_tready;
    assign push_last = push && s_tlast;
    assign pop_last  = pop && m_tlast;

    assign full_q = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        wr_ptr_d       = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d       = rd_ptr_q + (AW+1)'(pop);
        full_d         = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                         (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        s_tready_d     = !full_d;

        pkt_count_d    = pkt_count_q;
        if (push_last && !pop_last) begin
            pkt_count_d = pkt_count_q + CW'(1);
        end else if (pop_last && !push_last) begin
            pkt_count_d = pkt_count_q - CW'(1);
        end

        // An oversize packet fills the FIFO with no tlast inside: release it as cut-through.
        full_release_d = full_release_q;
        overflow_err_d = overflow_err_q;
        if (PACKET_MODE != 0) begin
            if (pop_last) begin
                full_release_d = 1'b0;
            end
            if (full_q && (pkt_count_q == '0)) begin
                full_release_d = 1'b1;
                overflow_err_d = 1'b1;
            end
        end

        // The head register only ever shows words written before this edge, which keeps the
        // s_* to m_* path registered and gives the one-cycle empty-to-valid latency.
        pkt_after_pop  = pkt_count_q - CW'(pop_last);
        pkt_ready      = (PACKET_MODE == 0) || (pkt_after_pop != '0) || full_release_d;
        m_tvalid_d     = (rd_ptr_d != wr_ptr_q) && pkt_ready;
    end

    // NOTE: storage and head data carry no reset; m_tvalid qualifies them, and a reset on a
    // RAM array would block inference of block/distributed memory.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= s_word;
        end
        head_q <= mem_q[rd_ptr_d[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            pkt_count_q    <= '0;
            m_tvalid_q     <= 1'b0;
            s_tready_q     <= 1'b0;
            full_release_q <= 1'b0;
            overflow_err_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            pkt_count_q    <= pkt_count_d;
            m_tvalid_q     <= m_tvalid_d;
            s_tready_q     <= s_tready_d;
            full_release_q <= full_release_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    assign s_tready     = s_tready_q;
    assign m_tvalid     = m_tvalid_q;
    assign word_count   = CW'(wr_ptr_q - rd_ptr_q);
    assign pkt_count    = pkt_count_q;
    assign overflow_err = overflow_err_q;

endmodule

// File: tb/tb_axi_stream_pkt_fifo.sv
// Directed bench for axi_stream_pkt_fifo: one cut-through and one packet-mode instance share
// the slave-side stimulus; each scenario starts from reset and targets one of them.
module tb_axi_stream_pkt_fifo;

    localparam int DW    = 64;
    localparam int KW    = DW / 8;
    localparam int IW    = 4;
    localparam int DSW   = 4;
    localparam int UW    = 2;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = DW + 2 * KW + 1 + IW + DSW + UW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           s_tvalid = 1'b0;
    logic [DW-1:0]  s_tdata  = '0;
    logic [KW-1:0]  s_tstrb  = '0;
    logic [KW-1:0]  s_tkeep  = '0;
    logic           s_tlast  = 1'b0;
    logic [IW-1:0]  s_tid    = '0;
    logic [DSW-1:0] s_tdest  = '0;
    logic [UW-1:0]  s_tuser  = '0;

    logic c_s_tready, c_m_tvalid, c_m_tlast, c_overflow_err;
    logic c_m_tready = 1'b0;
    logic [DW-1:0]  c_m_tdata;
    logic [KW-1:0]  c_m_tstrb, c_m_tkeep;
    logic [IW-1:0]  c_m_tid;
    logic [DSW-1:0] c_m_tdest;
    logic [UW-1:0]  c_m_tuser;
    logic [CW-1:0]  c_word_count, c_pkt_count;

    logic p_s_tready, p_m_tvalid, p_m_tlast, p_overflow_err;
    logic p_m_tready = 1'b0;
    logic [DW-1:0]  p_m_tdata;
    logic [KW-1:0]  p_m_tstrb, p_m_tkeep;
    logic [IW-1:0]  p_m_tid;
    logic [DSW-1:0] p_m_tdest;
    logic [UW-1:0]  p_m_tuser;
    logic [CW-1:0]  p_word_count, p_pkt_count;

    axi_stream_pkt_fifo #(
        .TDATA_WIDTH(DW), .TID_WIDTH(IW), .TDEST_WIDTH(DSW), .TUSER_WIDTH(UW),
        .DEPTH(DEPTH), .PACKET_MODE(0)
    ) dut_ct (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tready(c_s_tready), .s_tdata(s_tdata), .s_tstrb(s_tstrb),
        .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
        .m_tvalid(c_m_tvalid), .m_tready(c_m_tready), .m_tdata(c_m_tdata), .m_tstrb(c_m_tstrb),
        .m_tkeep(c_m_tkeep), .m_tlast(c_m_tlast), .m_tid(c_m_tid), .m_tdest(c_m_tdest),
        .m_tuser(c_m_tuser),
        .word_count(c_word_count), .pkt_count(c_pkt_count), .overflow_err(c_overflow_err)
    );

    axi_stream_pkt_fifo #(
        .TDATA_WIDTH(DW), .TID_WIDTH(IW), .TDEST_WIDTH(DSW), .TUSER_WIDTH(UW),
        .DEPTH(DEPTH), .PACKET_MODE(1)
    ) dut_pm (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tready(p_s_tready), .s_tdata(s_tdata), .s_tstrb(s_tstrb),
        .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
        .m_tvalid(p_m_tvalid), .m_tready(p_m_tready), .m_tdata(p_m_tdata), .m_tstrb(p_m_tstrb),
        .m_tkeep(p_m_tkeep), .m_tlast(p_m_tlast), .m_tid(p_m_tid), .m_tdest(p_m_tdest),
        .m_tuser(p_m_tuser),
        .word_count(p_word_count), .pkt_count(p_pkt_count), .overflow_err(p_overflow_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] c_out();
        return {c_m_tdata, c_m_tstrb, c_m_tkeep, c_m_tlast, c_m_tid, c_m_tdest, c_m_tuser};
    endfunction

    function automatic logic [PW-1:0] s_in();
        return {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [DW-1:0] d, input logic last);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        s_tstrb  = '1;
        s_tkeep  = '1;
        s_tid    = '0;
        s_tdest  = '0;
        s_tuser  = '0;
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        s_tvalid   = 1'b0;
        c_m_tready = 1'b0;
        p_m_tready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    logic [PW-1:0] sb_q[$];
    logic [PW-1:0] pend_w, held_w, exp_w;
    logic          pend, held, go;
    int            tx, rx;

    initial begin
        // Reset state while rst is held from time zero.
        #2;
        check("rst_m_tvalid",   128'(c_m_tvalid),     128'(0));
        check("rst_s_tready",   128'(c_s_tready),     128'(0));
        check("rst_word_count", 128'(c_word_count),   128'(0));
        check("rst_pkt_count",  128'(c_pkt_count),    128'(0));
        check("rst_overflow",   128'(p_overflow_err), 128'(0));
        tick();
        rst = 1'b0;
        check("rel_s_tready_pre", 128'(c_s_tready), 128'(0));
        tick();
        check("rel_s_tready", 128'(c_s_tready), 128'(1));

        // Cut-through: three words, one-cycle latency, in-order with tlast on the third.
        c_m_tready = 1'b1;
        drive(64'h11, 1'b0);
        tick();
        check("ct_lat_not_yet", 128'(c_m_tvalid), 128'(0));
        drive(64'h22, 1'b0);
        tick();
        check("ct_v1",  128'(c_m_tvalid), 128'(1));
        check("ct_d1",  128'(c_m_tdata),  128'(64'h11));
        check("ct_l1",  128'(c_m_tlast),  128'(0));
        check("ct_wc2", 128'(c_word_count), 128'(2));
        drive(64'h33, 1'b1);
        tick();
        s_tvalid = 1'b0;
        check("ct_d2",  128'(c_m_tdata), 128'(64'h22));
        check("ct_l2",  128'(c_m_tlast), 128'(0));
        tick();
        check("ct_d3",  128'(c_m_tdata), 128'(64'h33));
        check("ct_l3",  128'(c_m_tlast), 128'(1));
        check("ct_pc1", 128'(c_pkt_count), 128'(1));
        tick();
        check("ct_empty_v",  128'(c_m_tvalid),   128'(0));
        check("ct_empty_wc", 128'(c_word_count), 128'(0));
        check("ct_empty_pc", 128'(c_pkt_count),  128'(0));

        // Fill to DEPTH with the consumer stalled, then pop exactly one word.
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(DW'(i), 1'b0);
            tick();
        end
        s_tvalid = 1'b0;
        check("full_s_tready", 128'(c_s_tready),   128'(0));
        check("full_wc",       128'(c_word_count), 128'(DEPTH));
        check("full_head",     128'(c_m_tdata),    128'(0));
        c_m_tready = 1'b1;
        tick();
        c_m_tready = 1'b0;
        check("pop1_s_tready", 128'(c_s_tready),   128'(1));
        check("pop1_wc",       128'(c_word_count), 128'(DEPTH - 1));
        check("pop1_head",     128'(c_m_tdata),    128'(1));

        // Store-and-forward: nothing leaves until the tlast word is stored.
        apply_reset();
        p_m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(64'hA0 + DW'(i), i == 3);
            tick();
            check("pm_hold_v", 128'(p_m_tvalid), 128'(0));
        end
        s_tvalid = 1'b0;
        check("pm_pc1", 128'(p_pkt_count), 128'(1));
        for (int i = 0; i < 4; i++) begin
            tick();
            check("pm_burst_v", 128'(p_m_tvalid), 128'(1));
            check("pm_burst_d", 128'(p_m_tdata),  128'(64'hA0 + i));
            check("pm_burst_l", 128'(p_m_tlast),  128'(i == 3));
        end
        tick();
        check("pm_done_v",  128'(p_m_tvalid),     128'(0));
        check("pm_pc0",     128'(p_pkt_count),    128'(0));
        check("pm_no_ovf",  128'(p_overflow_err), 128'(0));

        // Store-and-forward with a 20-word packet that never ends: full release path.
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(64'h100 + DW'(i), 1'b0);
            tick();
        end
        s_tvalid = 1'b0;
        check("os_full_rdy", 128'(p_s_tready),   128'(0));
        check("os_full_wc",  128'(p_word_count), 128'(DEPTH));
        tick();
        check("os_rel_v",   128'(p_m_tvalid),     128'(1));
        check("os_ovf",     128'(p_overflow_err), 128'(1));
        check("os_rel_d",   128'(p_m_tdata),      128'(64'h100));
        p_m_tready = 1'b1;
        tx = DEPTH;
        rx = 0;
        for (int cyc = 0; cyc < 200 && rx < 20; cyc++) begin
            if (p_m_tvalid) begin
                check("os_word", 128'(p_m_tdata), 128'(64'h100 + rx));
                rx++;
            end
            go = 1'b0;
            if (tx < 20) begin
                drive(64'h100 + DW'(tx), 1'b0);
                go = p_s_tready;
            end else begin
                s_tvalid = 1'b0;
            end
            tick();
            if (go) tx++;
        end
        s_tvalid = 1'b0;
        check("os_count",    128'(rx),             128'(20));
        check("os_ovf_kept", 128'(p_overflow_err), 128'(1));
        check("os_wc0",      128'(p_word_count),   128'(0));

        // Random valid/ready with full sideband; scoreboard and stall stability.
        apply_reset();
        tx   = 0;
        rx   = 0;
        pend = 1'b0;
        held = 1'b0;
        for (int cyc = 0; cyc < 20000 && rx < 1000; cyc++) begin
            c_m_tready = 1'($urandom_range(0, 1));
            if (held) begin
                check("rand_stable", 128'({c_m_tvalid, c_out()}), 128'({1'b1, held_w}));
            end
            if (c_m_tvalid && c_m_tready) begin
                exp_w = (sb_q.size() != 0) ? sb_q.pop_front() : 'x;
                check("rand_word", 128'(c_out()), 128'(exp_w));
                rx++;
            end
            held   = c_m_tvalid && !c_m_tready;
            held_w = c_out();
            if (!pend && tx < 1000 && $urandom_range(0, 1) == 1) begin
                pend    = 1'b1;
                s_tdata = {$urandom, $urandom};
                s_tstrb = KW'($urandom);
                s_tkeep = KW'($urandom);
                s_tlast = ($urandom_range(0, 7) == 0);
                s_tid   = IW'($urandom);
                s_tdest = DSW'($urandom);
                s_tuser = UW'($urandom);
                pend_w  = s_in();
            end
            s_tvalid = pend;
            go = pend && c_s_tready;
            tick();
            if (go) begin
                sb_q.push_back(pend_w);
                pend = 1'b0;
                tx++;
            end
        end
        s_tvalid   = 1'b0;
        c_m_tready = 1'b0;
        check("rand_count", 128'(rx),           128'(1000));
        check("rand_wc0",   128'(c_word_count), 128'(0));
        check("rand_pc0",   128'(c_pkt_count),  128'(0));

        // Asynchronous reset with a partial packet stored.
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(64'h50 + DW'(i), i == 2);
            tick();
        end
        s_tvalid = 1'b0;
        tick();
        check("mid_wc5", 128'(c_word_count), 128'(5));
        check("mid_pc1", 128'(c_pkt_count),  128'(1));
        check("mid_v1",  128'(c_m_tvalid),   128'(1));
        #2;
        rst = 1'b1;
        #1;
        check("arst_v",   128'(c_m_tvalid),   128'(0));
        check("arst_wc",  128'(c_word_count), 128'(0));
        check("arst_pc",  128'(c_pkt_count),  128'(0));
        check("arst_rdy", 128'(c_s_tready),   128'(0));
        tick();
        tick();
        rst = 1'b0;
        check("arel_rdy_pre", 128'(c_s_tready), 128'(0));
        tick();
        check("arel_rdy",  128'(c_s_tready),   128'(1));
        check("arel_v",    128'(c_m_tvalid),   128'(0));
        check("arel_wc",   128'(c_word_count), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
